// File: rtl/tx_buffer_pkg.sv
// Shared definitions for the transmit message buffer: sizes and FSM state encoding.
package tx_buffer_pkg;

  // Bytes per message (descriptor plus data).
  localparam int BUF_DEPTH = 13;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    ACTV = 2'b10
  } tx_state_t;

  // True when a byte address falls inside the message; 13..15 are holes.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/tx_buffer_buf.sv
// Message storage: one host write port and two zero-latency read ports
// (host readback and transmit engine). Out-of-range addresses read as 0x00.
module tx_buf_13x8
  import tx_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rsn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte array: cleared by reset, otherwise written one byte per cycle.
  always_ff @(posedge clk) begin
    if (rsn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && addr_ok(wr_addr, DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Host readback port.
  always_comb begin
    rd_a_data = '0;
    if (addr_ok(rd_a_addr, DEPTH)) begin
      rd_a_data = mem[rd_a_addr];
    end
  end

  // Transmit engine read port.
  always_comb begin
    rd_b_data = '0;
    if (addr_ok(rd_b_addr, DEPTH)) begin
      rd_b_data = mem[rd_b_addr];
    end
  end

endmodule

// File: rtl/tx_buffer.sv
// Transmit message buffer: host fills the message, requests transmission,
// and the core engine reports start/done/error. Owns the handshake FSM.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | buffer released to host; writes accepted (tbs=1)
//   PEND  | message locked, waiting for the core to start a frame (c_req=1)
//   ACTV  | core is sending the frame from this buffer (busy=1)
//
// ab: abort requested while the frame is pending start or on the wire.
// ss: single-shot request, no automatic retransmit after an error.
module tx_buffer
  import tx_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rsn,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_din,
  input  logic              h_wrn,
  output logic [DATA_W-1:0] h_dout,
  input  logic              cmd_tr,
  input  logic              cmd_at,
  input  logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_dout,
  output logic              c_req,
  input  logic              c_start,
  input  logic              c_done,
  input  logic              c_err,
  output logic              tbs,
  output logic              tcs,
  output logic              busy
);

  tx_state_t state_q, state_d;
  logic      tcs_q, tcs_d;
  logic      ab_q, ab_d;
  logic      ss_q, ss_d;
  logic      abort_now;
  logic      tbs_q, c_req_q, busy_q;
  logic      wr_en;

  // Writes are only accepted while the host owns the buffer; range check lives in storage.
  assign wr_en = ~h_wrn && (state_q == IDLE);

  tx_buf_13x8 #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .rsn      (rsn),
    .wr_en    (wr_en),
    .wr_addr  (h_addr),
    .wr_data  (h_din),
    .rd_a_addr(h_addr),
    .rd_a_data(h_dout),
    .rd_b_addr(c_addr),
    .rd_b_data(c_dout)
  );

  // Next-state and flag update logic.
  always_comb begin
    state_d   = state_q;
    tcs_d     = tcs_q;
    ab_d      = ab_q;
    ss_d      = ss_q;
    abort_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_tr) begin
          state_d = PEND;
          tcs_d   = 1'b0;
          ss_d    = cmd_at;
          ab_d    = 1'b0;
        end
      end
      PEND: begin
        if (c_start) begin
          state_d = ACTV;
          ab_d    = cmd_at;
        end else if (cmd_at) begin
          state_d = IDLE;
          ab_d    = 1'b0;
          ss_d    = 1'b0;
        end
      end
      ACTV: begin
        // An abort arriving together with c_err already suppresses the retry.
        abort_now = ab_q | cmd_at;
        ab_d      = abort_now;
        if (c_done) begin
          state_d = IDLE;
          tcs_d   = 1'b1;
          ab_d    = 1'b0;
          ss_d    = 1'b0;
        end else if (c_err) begin
          if (abort_now || ss_q) begin
            state_d = IDLE;
            ab_d    = 1'b0;
            ss_d    = 1'b0;
          end else begin
            state_d = PEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ab_d    = 1'b0;
        ss_d    = 1'b0;
      end
    endcase
  end

  // State, flags and registered status outputs.
  always_ff @(posedge clk) begin
    if (rsn) begin
      state_q <= IDLE;
      tcs_q   <= 1'b1;
      ab_q    <= 1'b0;
      ss_q    <= 1'b0;
      tbs_q   <= 1'b1;
      c_req_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcs_q   <= tcs_d;
      ab_q    <= ab_d;
      ss_q    <= ss_d;
      tbs_q   <= (state_d == IDLE);
      c_req_q <= (state_d == PEND);
      busy_q  <= (state_d == ACTV);
    end
  end

  assign tbs   = tbs_q;
  assign tcs   = tcs_q;
  assign c_req = c_req_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_tx_buffer.sv
// Self-checking bench for tx_buffer: directed scenarios, a vector table for the
// handshake corners, and randomized traffic against a flag-based reference model.
module tb_tx_buffer;

  logic       clk = 1'b0;
  logic       rsn, h_wrn, cmd_tr, cmd_at, c_start, c_done, c_err;
  logic [3:0] h_addr, c_addr;
  logic [7:0] h_din, h_dout, c_dout;
  logic       c_req, tbs, tcs, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_buffer #(.DEPTH(13)) dut (
    .clk    (clk),
    .rsn    (rsn),
    .h_addr (h_addr),
    .h_din  (h_din),
    .h_wrn  (h_wrn),
    .h_dout (h_dout),
    .cmd_tr (cmd_tr),
    .cmd_at (cmd_at),
    .c_addr (c_addr),
    .c_dout (c_dout),
    .c_req  (c_req),
    .c_start(c_start),
    .c_done (c_done),
    .c_err  (c_err),
    .tbs    (tbs),
    .tcs    (tcs),
    .busy   (busy)
  );

  typedef struct {
    logic       tr, at, st, dn, er;
    logic [3:0] ha, ca;
    logic       e_tbs, e_tcs, e_req, e_busy;
    logic [7:0] e_hd, e_cd;
  } vec_t;

  vec_t tbl[$];

  // Reference model: who owns the buffer, plus the message image.
  bit         m_host, m_wait, m_air, m_tcs, m_ab, m_ss;
  logic [7:0] m_mem [13];

  function automatic vec_t v(input logic tr, at, st, dn, er, input logic [3:0] ha, ca,
                             input logic e_tbs, e_tcs, e_req, e_busy,
                             input logic [7:0] e_hd, e_cd);
    vec_t r;
    r.tr = tr; r.at = at; r.st = st; r.dn = dn; r.er = er;
    r.ha = ha; r.ca = ca;
    r.e_tbs = e_tbs; r.e_tcs = e_tcs; r.e_req = e_req; r.e_busy = e_busy;
    r.e_hd = e_hd; r.e_cd = e_cd;
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rsn = 1'b0; h_wrn = 1'b1; h_din = 8'h00;
    cmd_tr = 1'b0; cmd_at = 1'b0;
    c_start = 1'b0; c_done = 1'b0; c_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string nm, input logic e_tbs, e_tcs, e_req, e_busy);
    check({nm, "_tbs"},   8'(tbs),   8'(e_tbs));
    check({nm, "_tcs"},   8'(tcs),   8'(e_tcs));
    check({nm, "_c_req"}, 8'(c_req), 8'(e_req));
    check({nm, "_busy"},  8'(busy),  8'(e_busy));
  endtask

  function automatic logic [7:0] m_rd(input logic [3:0] a);
    return (a <= 4'd12) ? m_mem[a] : 8'h00;
  endfunction

  task automatic model_reset();
    m_host = 1'b1; m_wait = 1'b0; m_air = 1'b0;
    m_tcs = 1'b1; m_ab = 1'b0; m_ss = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit abort;
    if (rsn) begin
      model_reset();
      return;
    end
    if (!h_wrn && m_host && h_addr <= 4'd12) m_mem[h_addr] = h_din;
    if (m_host) begin
      if (cmd_tr) begin
        m_host = 1'b0; m_wait = 1'b1; m_tcs = 1'b0; m_ss = cmd_at; m_ab = 1'b0;
      end
    end else if (m_wait) begin
      if (c_start) begin
        m_wait = 1'b0; m_air = 1'b1; m_ab = cmd_at;
      end else if (cmd_at) begin
        m_wait = 1'b0; m_host = 1'b1; m_ss = 1'b0;
      end
    end else begin
      abort = m_ab || cmd_at;
      if (c_done) begin
        m_air = 1'b0; m_host = 1'b1; m_tcs = 1'b1; m_ab = 1'b0; m_ss = 1'b0;
      end else if (c_err && (abort || m_ss)) begin
        m_air = 1'b0; m_host = 1'b1; m_ab = 1'b0; m_ss = 1'b0;
      end else if (c_err) begin
        m_air = 1'b0; m_wait = 1'b1;
      end else begin
        m_ab = abort;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        tr at st dn er  ha     ca     tbs tcs req bsy  hd     cd
    tbl.push_back(v(0,0,1,0,0, 4'd0,  4'd12, 0,0,0,1, 8'h01, 8'h0D)); // start
    tbl.push_back(v(0,0,0,0,1, 4'd1,  4'd11, 0,0,1,0, 8'h02, 8'h0C)); // err -> retry
    tbl.push_back(v(0,0,1,0,0, 4'd2,  4'd10, 0,0,0,1, 8'h03, 8'h0B));
    tbl.push_back(v(0,0,0,1,0, 4'd3,  4'd9,  1,1,0,0, 8'h04, 8'h0A)); // done
    tbl.push_back(v(1,1,0,0,0, 4'd4,  4'd8,  0,0,1,0, 8'h05, 8'h09)); // single shot
    tbl.push_back(v(0,0,1,0,0, 4'd5,  4'd7,  0,0,0,1, 8'h06, 8'h08));
    tbl.push_back(v(0,0,0,0,1, 4'd6,  4'd6,  1,0,0,0, 8'h07, 8'h07)); // no retry
    tbl.push_back(v(0,0,0,0,0, 4'd7,  4'd5,  1,0,0,0, 8'h08, 8'h06));
    tbl.push_back(v(1,0,0,0,0, 4'd8,  4'd4,  0,0,1,0, 8'h09, 8'h05));
    tbl.push_back(v(0,0,1,0,0, 4'd9,  4'd3,  0,0,0,1, 8'h0A, 8'h04));
    tbl.push_back(v(0,1,0,0,0, 4'd10, 4'd2,  0,0,0,1, 8'h0B, 8'h03)); // abort in ACTV
    tbl.push_back(v(0,0,0,1,0, 4'd11, 4'd1,  1,1,0,0, 8'h0C, 8'h02)); // done despite ab
    tbl.push_back(v(1,0,0,0,0, 4'd12, 4'd0,  0,0,1,0, 8'h0D, 8'h01));
    tbl.push_back(v(0,0,1,0,0, 4'd13, 4'd14, 0,0,0,1, 8'h00, 8'h00));
    tbl.push_back(v(0,1,0,0,0, 4'd14, 4'd15, 0,0,0,1, 8'h00, 8'h00));
    tbl.push_back(v(0,0,0,0,1, 4'd15, 4'd13, 1,0,0,0, 8'h00, 8'h00)); // err with ab
    tbl.push_back(v(0,1,0,0,0, 4'd0,  4'd5,  1,0,0,0, 8'h01, 8'h06)); // cmd_at alone in IDLE
    tbl.push_back(v(0,0,1,1,1, 4'd0,  4'd5,  1,0,0,0, 8'h01, 8'h06)); // core pulses in IDLE
    tbl.push_back(v(1,0,0,0,0, 4'd0,  4'd5,  0,0,1,0, 8'h01, 8'h06));
    tbl.push_back(v(1,0,0,1,1, 4'd0,  4'd5,  0,0,1,0, 8'h01, 8'h06)); // ignored in PEND
    tbl.push_back(v(0,1,0,0,0, 4'd0,  4'd5,  1,0,0,0, 8'h01, 8'h06)); // abort in PEND
    tbl.push_back(v(1,0,0,0,0, 4'd0,  4'd5,  0,0,1,0, 8'h01, 8'h06));
    tbl.push_back(v(0,1,1,0,0, 4'd0,  4'd5,  0,0,0,1, 8'h01, 8'h06)); // start+abort
    tbl.push_back(v(0,0,0,0,1, 4'd0,  4'd5,  1,0,0,0, 8'h01, 8'h06));
    tbl.push_back(v(1,0,0,0,0, 4'd0,  4'd5,  0,0,1,0, 8'h01, 8'h06));
    tbl.push_back(v(0,0,1,0,0, 4'd0,  4'd5,  0,0,0,1, 8'h01, 8'h06));
    tbl.push_back(v(1,0,1,0,0, 4'd0,  4'd5,  0,0,0,1, 8'h01, 8'h06)); // tr/start in ACTV
    tbl.push_back(v(0,0,0,1,1, 4'd0,  4'd5,  1,1,0,0, 8'h01, 8'h06)); // done beats err

    idle_inputs();
    h_addr = 4'd0; c_addr = 4'd0;
    rsn = 1'b1;
    tick();
    check_status("reset", 1, 1, 0, 0);
    check("reset_h_dout", h_dout, 8'h00);
    rsn = 1'b0;

    // Fill the message with 0x01..0x0D.
    for (int i = 0; i < 13; i++) begin
      h_addr = 4'(i); h_din = 8'(i + 1); h_wrn = 1'b0;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 13; i++) begin
      h_addr = 4'(i); c_addr = 4'(12 - i);
      #1;
      check("fill_h_dout", h_dout, 8'(i + 1));
      check("fill_c_dout", c_dout, 8'(13 - i));
    end
    cmd_tr = 1'b1;
    tick();
    idle_inputs();
    c_addr = 4'd5;
    #1;
    check_status("req", 0, 0, 1, 0);
    check("req_c_dout5", c_dout, 8'h06);

    foreach (tbl[k]) begin
      idle_inputs();
      cmd_tr = tbl[k].tr; cmd_at = tbl[k].at;
      c_start = tbl[k].st; c_done = tbl[k].dn; c_err = tbl[k].er;
      h_addr = tbl[k].ha; c_addr = tbl[k].ca;
      tick();
      check_status($sformatf("vec%0d", k), tbl[k].e_tbs, tbl[k].e_tcs, tbl[k].e_req, tbl[k].e_busy);
      check($sformatf("vec%0d_h_dout", k), h_dout, tbl[k].e_hd);
      check($sformatf("vec%0d_c_dout", k), c_dout, tbl[k].e_cd);
    end
    idle_inputs();

    // Writes while locked are dropped; holes read as zero and do not alias.
    cmd_tr = 1'b1;
    tick();
    idle_inputs();
    check("lock_c_req", 8'(c_req), 8'h01);
    h_addr = 4'd3; h_din = 8'hAA; h_wrn = 1'b0;
    tick();
    h_wrn = 1'b1;
    #1;
    check("locked_write", h_dout, 8'h04);
    cmd_at = 1'b1;
    tick();
    idle_inputs();
    check_status("pend_abort", 1, 0, 0, 0);
    h_addr = 4'd14; h_din = 8'h55; h_wrn = 1'b0;
    tick();
    h_wrn = 1'b1;
    #1;
    check("hole_write", h_dout, 8'h00);
    h_addr = 4'd6;
    #1;
    check("hole_alias", h_dout, 8'h07);

    // Write in the same cycle as the request is kept.
    h_addr = 4'd2; h_din = 8'h5A; h_wrn = 1'b0; cmd_tr = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("wr_with_tr", h_dout, 8'h5A);
    check("wr_with_tr_req", 8'(c_req), 8'h01);

    // Reset while transmitting, with c_done and a host write in the same cycle.
    c_start = 1'b1;
    tick();
    idle_inputs();
    check("actv_busy", 8'(busy), 8'h01);
    rsn = 1'b1; c_done = 1'b1; h_wrn = 1'b0; h_addr = 4'd0; h_din = 8'hFF;
    tick();
    idle_inputs();
    check_status("rst_actv", 1, 1, 0, 0);
    for (int i = 0; i < 13; i++) begin
      h_addr = 4'(i); c_addr = 4'(i);
      #1;
      check("rst_clear_h", h_dout, 8'h00);
      check("rst_clear_c", c_dout, 8'h00);
    end

    // Randomized traffic against the reference model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rsn     = ($urandom_range(63) == 0);
      h_wrn   = 1'($urandom_range(1));
      h_addr  = 4'($urandom_range(15));
      h_din   = 8'($urandom);
      c_addr  = 4'($urandom_range(15));
      cmd_tr  = ($urandom_range(5) == 0);
      cmd_at  = ($urandom_range(9) == 0);
      c_start = ($urandom_range(3) == 0);
      c_done  = ($urandom_range(5) == 0);
      c_err   = ($urandom_range(5) == 0);
      #1;
      check("rnd_h_dout", h_dout, m_rd(h_addr));
      check("rnd_c_dout", c_dout, m_rd(c_addr));
      model_step();
      tick();
      check_status("rnd", m_host, m_tcs, m_wait, m_air);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
